inv_shift_rows_stream: RTL

Byte-serial InvShiftRows stage for the AES-128 decryption path. It accepts the 16 state bytes one per cycle over a valid/ready handshake, assembles the 128-bit state, and applies the inverse row rotation (row r rotated right by r). It presents the result as a registered 128-bit block with its own valid/ready handshake. A single output holding register lets the next block fill while the previous one waits for the downstream consumer.

---
 rtl/inv_shift_rows_stream.sv | 97 +++++++++
 1 files changed

// File: rtl/inv_shift_rows_stream.sv
// Byte-serial AES-128 InvShiftRows: collects 16 column-major bytes, rotates
// row r right by r, and holds the result in one output register.
module inv_shift_rows_stream (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clear,
  input  logic [7:0]   i_byte,
  input  logic         i_valid,
  output logic         o_ready,
  output logic [127:0] o_state,
  output logic         o_valid,
  input  logic         i_ready
);

  typedef enum logic {FILL, FULL} st_e;

  st_e                st_q, st_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [15:0][7:0]   buf_q, buf_d;   // index k holds column-major byte k
  logic [127:0]       out_q, out_d;
  logic               vld_q, vld_d;
  logic [127:0]       map_d;
  logic               in_xfer, out_xfer;

  assign o_ready  = (st_q == FILL);
  assign in_xfer  = i_valid & o_ready;
  assign out_xfer = vld_q & i_ready;
  assign o_state  = out_q;
  assign o_valid  = vld_q;

  always_comb begin
    buf_d = buf_q;
    if (!i_clear && in_xfer) buf_d[cnt_q] = i_byte;
  end

  // Mapping is taken from buf_d so the 16th byte lands in the same cycle it arrives.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign map_d[127-8*(4*c+r) -: 8] = buf_d[4*((c-r+4)%4)+r];
    end
  end

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    out_d = out_q;
    vld_d = vld_q;
    if (i_clear) begin
      st_d  = FILL;
      cnt_d = 4'd0;
      vld_d = 1'b0;
    end else begin
      if (out_xfer) vld_d = 1'b0;
      case (st_q)
        FILL: begin
          if (in_xfer) begin
            if (cnt_q == 4'd15) begin
              cnt_d = 4'd0;
              if (!vld_q || out_xfer) begin
                out_d = map_d;
                vld_d = 1'b1;
              end else begin
                st_d = FULL;
              end
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end
        end
        FULL: begin
          if (out_xfer) begin
            out_d = map_d;
            vld_d = 1'b1;
            st_d  = FILL;
          end
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      st_q  <= FILL;
      cnt_q <= 4'd0;
      buf_q <= '0;
      out_q <= '0;
      vld_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      buf_q <= buf_d;
      out_q <= out_d;
      vld_q <= vld_d;
    end
  end

endmodule
